// File: rtl/keccak_msg_padder_pkg.sv
// Shared types and constants for the Keccak message padder.
// Build option PADDER_BYTE_SWAP_EN (see pad_word_gen) selects big-endian lane packing.
package keccak_msg_padder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StPad,
      StStart,
      StWaitDone,
      StError
   } pad_state_t;

   localparam int unsigned RATE_BYTES_DEF = 168;
   localparam logic [7:0]  DSEP_SHA3      = 8'h06;
   localparam logic [7:0]  DSEP_SHAKE     = 8'h1F;

endpackage

// File: rtl/keccak_msg_padder_if.sv
// Message-in, RAM-write and accelerator-control bundle for keccak_msg_padder.
interface keccak_msg_padder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  msg_start;
   logic [7:0]            msg_len;
   logic [7:0]            dsep;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0]            in_data;
   logic                  abort;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_be;
   logic                  accel_start;
   logic                  accel_done;
   logic                  busy;
   logic                  error;

   modport master (
      output msg_start, msg_len, dsep, in_valid, in_data, abort, accel_done,
      input  in_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be, accel_start, busy, error
   );

   modport slave (
      input  msg_start, msg_len, dsep, in_valid, in_data, abort, accel_done,
      output in_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be, accel_start, busy, error
   );
endinterface

// File: rtl/keccak_msg_padder_pad_word_gen.sv
// Combinational pad10*1 word builder. PADDER_BYTE_SWAP_EN defined: big-endian lanes,
// otherwise lane n sits in word[8n+7:8n].
module pad_word_gen
   import keccak_msg_padder_pkg::*;
#(
   parameter int unsigned RATE_BYTES = RATE_BYTES_DEF
) (
   input  logic [7:0]  word_idx,
   input  logic [7:0]  len,
   input  logic [7:0]  dsep,
   input  logic [31:0] lanes,
   output logic [31:0] padded
);

   logic [9:0] idx;
   logic [7:0] b;

   always_comb begin
      padded = '0;
      idx    = '0;
      b      = '0;
      for (int n = 0; n < 4; n++) begin
         idx = {word_idx, 2'(n)};
         if (idx < {2'b00, len}) begin
            b = lanes[8*n +: 8];
         end else if (idx == {2'b00, len}) begin
            b = dsep;
         end else begin
            b = 8'h00;
         end
         if (idx == 10'(RATE_BYTES - 1)) begin
            b = b | 8'h80;
         end
`ifdef PADDER_BYTE_SWAP_EN
         padded[8*(3-n) +: 8] = b;
`else
         padded[8*n +: 8] = b;
`endif
      end
   end

endmodule

// File: rtl/keccak_msg_padder.sv
// Packs a single-block message into 32-bit RAM words with pad10*1 padding, then kicks the
// accelerator. Lane order follows PADDER_BYTE_SWAP_EN (handled in pad_word_gen).
module keccak_msg_padder
   import keccak_msg_padder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RATE_BYTES = RATE_BYTES_DEF,
   parameter int unsigned BASE_ADDR  = 0
) (
   input logic                clk,
   input logic                rst_n,
   keccak_msg_padder_if.slave bus
);

   localparam int unsigned Words = RATE_BYTES / 4;

   pad_state_t            state_q;
   logic [7:0]            len_q;
   logic [7:0]            dsep_q;
   logic [7:0]            byte_cnt_q;
   logic [31:0]           lanes_q;
   logic [7:0]            pad_idx_q;
   logic                  mem_en_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  accel_start_q;

   logic [31:0] lanes_upd;
   logic        last_byte;
   logic        lane3;
   logic [7:0]  gen_idx;
   logic [7:0]  gen_len;
   logic [7:0]  gen_dsep;
   logic [31:0] gen_lanes;
   logic [31:0] gen_word;

   assign last_byte = (byte_cnt_q == len_q - 8'd1);
   assign lane3     = (byte_cnt_q[1:0] == 2'd3);

   always_comb begin
      lanes_upd = lanes_q;
      lanes_upd[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.in_data;
   end

   // One generator serves the zero-length start, full/last collected words and PAD words.
   always_comb begin
      gen_idx   = pad_idx_q;
      gen_len   = len_q;
      gen_dsep  = dsep_q;
      gen_lanes = lanes_q;
      if (state_q == StIdle) begin
         gen_idx   = '0;
         gen_len   = bus.msg_len;
         gen_dsep  = bus.dsep;
         gen_lanes = '0;
      end else if (state_q == StCollect) begin
         gen_idx   = {2'b00, byte_cnt_q[7:2]};
         gen_lanes = lanes_upd;
      end
   end

   pad_word_gen #(
      .RATE_BYTES (RATE_BYTES)
   ) u_pad_word_gen (
      .word_idx (gen_idx),
      .len      (gen_len),
      .dsep     (gen_dsep),
      .lanes    (gen_lanes),
      .padded   (gen_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         len_q         <= '0;
         dsep_q        <= '0;
         byte_cnt_q    <= '0;
         lanes_q       <= '0;
         pad_idx_q     <= '0;
         mem_en_q      <= 1'b0;
         mem_addr_q    <= ADDR_WIDTH'(BASE_ADDR);
         mem_wdata_q   <= '0;
         accel_start_q <= 1'b0;
      end else if (bus.abort) begin
         state_q       <= StIdle;
         len_q         <= '0;
         dsep_q        <= '0;
         byte_cnt_q    <= '0;
         lanes_q       <= '0;
         pad_idx_q     <= '0;
         mem_en_q      <= 1'b0;
         mem_addr_q    <= ADDR_WIDTH'(BASE_ADDR);
         mem_wdata_q   <= '0;
         accel_start_q <= 1'b0;
      end else begin
         mem_en_q      <= 1'b0;
         accel_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.msg_start) begin
                  if (32'(bus.msg_len) > RATE_BYTES - 1) begin
                     state_q <= StError;
                  end else begin
                     len_q      <= bus.msg_len;
                     dsep_q     <= bus.dsep;
                     byte_cnt_q <= '0;
                     lanes_q    <= '0;
                     if (bus.msg_len == 8'd0) begin
                        // Empty message: word 0 goes out on the same edge PAD is entered.
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(gen_idx);
                        mem_wdata_q <= DATA_WIDTH'(gen_word);
                        pad_idx_q   <= 8'd1;
                        state_q     <= StPad;
                     end else begin
                        state_q <= StCollect;
                     end
                  end
               end
            end
            StCollect: begin
               if (bus.in_valid) begin
                  lanes_q    <= lanes_upd;
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                  if (lane3 || last_byte) begin
                     mem_en_q    <= 1'b1;
                     mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(gen_idx);
                     mem_wdata_q <= DATA_WIDTH'(gen_word);
                  end
                  if (last_byte) begin
                     pad_idx_q <= gen_idx + 8'd1;
                     state_q   <= StPad;
                  end
               end
            end
            StPad: begin
               if (32'(pad_idx_q) == Words) begin
                  accel_start_q <= 1'b1;
                  state_q       <= StStart;
               end else begin
                  mem_en_q    <= 1'b1;
                  mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(gen_idx);
                  mem_wdata_q <= DATA_WIDTH'(gen_word);
                  pad_idx_q   <= pad_idx_q + 8'd1;
               end
            end
            StStart: begin
               state_q <= StWaitDone;
            end
            StWaitDone: begin
               if (bus.accel_done) begin
                  state_q <= StIdle;
               end
            end
            StError: begin
               state_q <= StError;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready    = (state_q == StCollect);
   assign bus.busy        = (state_q != StIdle) && (state_q != StError);
   assign bus.error       = (state_q == StError);
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_we      = mem_en_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_be      = 4'hF;
   assign bus.accel_start = accel_start_q;

endmodule

// File: tb/tb_keccak_msg_padder.sv
// Randomized self-checking bench for keccak_msg_padder against a byte-image model.
module tb_keccak_msg_padder;
   import keccak_msg_padder_pkg::*;

   localparam int unsigned RATE  = 168;
   localparam int unsigned WORDS = RATE / 4;
   localparam int unsigned BASE  = 32'h100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   keccak_msg_padder_if bus ();

   keccak_msg_padder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .RATE_BYTES (RATE),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_idx, starts, first_wr_cyc, last_wr_cyc, start_seen_cyc, start_cyc;
   logic [7:0]  msg[RATE];
   logic [7:0]  exp_bytes[RATE];
   logic [31:0] ram[WORDS];
   logic [31:0] ram_ref[WORDS];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] lit(input logic [31:0] le, input logic [31:0] be);
`ifdef PADDER_BYTE_SWAP_EN
      return be;
`else
      return le;
`endif
   endfunction

   // Block image straight from the padding rule: message, domain byte, zeros, final 0x80.
   task automatic set_model(input int len, input logic [7:0] ds);
      for (int i = 0; i < int'(RATE); i++) begin
         if (i < len) exp_bytes[i] = msg[i];
         else if (i == len) exp_bytes[i] = ds;
         else exp_bytes[i] = 8'h00;
      end
      exp_bytes[RATE-1] = exp_bytes[RATE-1] | 8'h80;
      for (int w = 0; w < int'(WORDS); w++) ram[w] = 32'hDEAD_BEEF;
      wr_idx = 0;
      starts = 0;
   endtask

   function automatic logic [31:0] exp_word(input int w);
      logic [31:0] r;
      for (int n = 0; n < 4; n++) begin
`ifdef PADDER_BYTE_SWAP_EN
         r[8*(3-n) +: 8] = exp_bytes[4*w + n];
`else
         r[8*n +: 8] = exp_bytes[4*w + n];
`endif
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_en) begin
            chk("mem_we", 32'(bus.mem_we), 32'd1);
            chk("mem_be", 32'(bus.mem_be), 32'hF);
            if (wr_idx < int'(WORDS)) begin
               chk("wr_addr", bus.mem_addr, BASE + 32'(wr_idx));
               chk("wr_data", bus.mem_wdata, exp_word(wr_idx));
               ram[wr_idx] = bus.mem_wdata;
            end else begin
               chk("wr_overflow", 32'(wr_idx), WORDS - 1);
            end
            if (wr_idx == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_idx++;
         end else begin
            chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
         end
         if (bus.accel_start) begin
            chk("start_after_writes", 32'(wr_idx), WORDS);
            chk("start_latency", 32'(cyc - last_wr_cyc), 32'd1);
            start_seen_cyc = cyc;
            starts++;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_accel_start"}, 32'(bus.accel_start), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_error"}, 32'(bus.error), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr, BASE);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'hF);
   endtask

   // mode: 0 continuous, 1 bubble before every byte, 2 random bubbles
   task automatic send(input int len, input logic [7:0] ds, input int mode, input int nbytes);
      @(posedge clk); #1;
      bus.msg_start = 1'b1;
      bus.msg_len   = 8'(len);
      bus.dsep      = ds;
      start_cyc     = cyc;
      @(posedge clk); #1;
      bus.msg_start = 1'b0;
      bus.msg_len   = 8'($urandom);
      bus.dsep      = 8'($urandom);
      for (int i = 0; i < nbytes; i++) begin
         if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = msg[i];
         chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
         chk("busy_collect", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
      end
      // Junk on the byte port after the message must be ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic finish_block(input int hold);
      for (int c = 0; c < 300 && starts == 0; c++) begin
         @(posedge clk); #1;
      end
      chk("accel_start_count", 32'(starts), 32'd1);
      chk("write_count", 32'(wr_idx), WORDS);
      for (int h = 0; h < hold; h++) begin
         chk("busy_wait_done", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
      end
      chk("busy_before_done", 32'(bus.busy), 32'd1);
      bus.accel_done = 1'b1;
      @(posedge clk); #1;
      bus.accel_done = 1'b0;
      bus.in_valid   = 1'b0;
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("in_ready_idle", 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int len;
      logic [7:0] ds;
      bus.msg_start  = 1'b0;
      bus.msg_len    = '0;
      bus.dsep       = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.abort      = 1'b0;
      bus.accel_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;

      // Empty message, SHAKE domain, cycle-exact timing.
      for (int i = 0; i < int'(RATE); i++) msg[i] = 8'($urandom);
      set_model(0, DSEP_SHAKE);
      send(0, DSEP_SHAKE, 0, 0);
      finish_block(2);
      chk("l0_word0", ram[0], lit(32'h0000_001F, 32'h1F00_0000));
      chk("l0_word20", ram[20], 32'h0);
      chk("l0_word41", ram[41], lit(32'h8000_0000, 32'h0000_0080));
      chk("l0_first_write_cycle", 32'(first_wr_cyc - start_cyc), 32'd1);
      chk("l0_accel_start_cycle", 32'(start_seen_cyc - start_cyc), 32'd43);

      // Five bytes.
      msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33; msg[3] = 8'h44; msg[4] = 8'h55;
      set_model(5, DSEP_SHAKE);
      send(5, DSEP_SHAKE, 0, 5);
      finish_block(1);
      chk("l5_word0", ram[0], lit(32'h4433_2211, 32'h1122_3344));
      chk("l5_word1", ram[1], lit(32'h0000_1F55, 32'h551F_0000));
      chk("l5_word41", ram[41], lit(32'h8000_0000, 32'h0000_0080));

      // Longest legal message: domain byte and final bit share byte 167.
      for (int i = 0; i < int'(RATE); i++) msg[i] = 8'(i);
      set_model(167, DSEP_SHA3);
      send(167, DSEP_SHA3, 0, 167);
      finish_block(0);
      chk("l167_word41", ram[41], lit(32'h86A6_A5A4, 32'hA4A5_A686));

      // Oversize lengths go to ERROR without touching RAM.
      for (int k = 0; k < 2; k++) begin
         len = (k == 0) ? 168 : int'($urandom_range(169, 255));
         set_model(0, DSEP_SHA3);
         @(posedge clk); #1;
         bus.msg_start = 1'b1;
         bus.msg_len   = 8'(len);
         @(posedge clk); #1;
         bus.msg_start = 1'b0;
         bus.in_valid  = 1'b1;
         chk("err_flag", 32'(bus.error), 32'd1);
         chk("err_in_ready", 32'(bus.in_ready), 32'd0);
         chk("err_busy", 32'(bus.busy), 32'd0);
         repeat (6) @(posedge clk);
         #1;
         chk("err_sticky", 32'(bus.error), 32'd1);
         chk("err_no_writes", 32'(wr_idx), 32'd0);
         bus.abort = 1'b1;
         @(posedge clk); #1;
         bus.abort    = 1'b0;
         bus.in_valid = 1'b0;
         check_reset_vals("err_abort");
      end

      // Bubbled input must give the same RAM image as continuous input.
      for (int i = 0; i < int'(RATE); i++) msg[i] = 8'($urandom);
      set_model(8, DSEP_SHA3);
      send(8, DSEP_SHA3, 0, 8);
      finish_block(3);
      for (int w = 0; w < int'(WORDS); w++) ram_ref[w] = ram[w];
      set_model(8, DSEP_SHA3);
      send(8, DSEP_SHA3, 1, 8);
      finish_block(5);
      for (int w = 0; w < int'(WORDS); w++) chk("bubble_image", ram[w], ram_ref[w]);

      // Abort during PAD.
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < int'(RATE); i++) msg[i] = 8'($urandom);
      set_model(len, DSEP_SHAKE);
      send(len, DSEP_SHAKE, 2, len);
      repeat (5) @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      check_reset_vals("pad_abort");
      repeat (60) @(posedge clk);
      #1;
      chk("pad_abort_no_start", 32'(starts), 32'd0);

      // Reset in the middle of COLLECT.
      set_model(20, DSEP_SHA3);
      send(20, DSEP_SHA3, 0, 6);
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      check_reset_vals("rst_release");
      repeat (60) @(posedge clk);
      #1;
      chk("rst_no_start", 32'(starts), 32'd0);

      // Randomized messages, including lane-3 and single-byte corners.
      for (int k = 0; k < 9; k++) begin
         if (k == 0) len = 4;
         else if (k == 1) len = 164;
         else if (k == 2) len = 1;
         else len = int'($urandom_range(1, 167));
         ds = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (k[0] ? DSEP_SHA3 : DSEP_SHAKE);
         for (int i = 0; i < int'(RATE); i++) msg[i] = 8'($urandom);
         set_model(len, ds);
         send(len, ds, int'($urandom_range(0, 2)), len);
         finish_block(int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
